// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int unsigned NumReqDef    = 4;
  localparam int unsigned DataWidthDef = 8;
  localparam int unsigned MaxBurstDef  = 4;
  localparam int unsigned IdWidthDef   = 2;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set bit of req_i searching start_i, start_i+1, ... (mod NUM_REQ).
module rr_pick #(
  parameter int unsigned NUM_REQ  = fifo_pkg::NumReqDef,
  parameter int unsigned ID_WIDTH = fifo_pkg::IdWidthDef
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [ID_WIDTH-1:0] start_i,
  output logic                found_o,
  output logic [ID_WIDTH-1:0] idx_o
);

  // Walk the circular order once; the first hit wins.
  always_comb begin : p_search
    int unsigned k;
    found_o = 1'b0;
    idx_o   = '0;
    k       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = (32'(start_i) + i) % NUM_REQ;
      if (!found_o && (|(req_i & (NUM_REQ'(1) << k)))) begin
        found_o = 1'b1;
        idx_o   = ID_WIDTH'(k);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready/last producers.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NumReqDef,
  parameter int unsigned DATA_WIDTH = DataWidthDef,
  parameter int unsigned MAX_BURST  = MaxBurstDef,
  parameter int unsigned ID_WIDTH   = IdWidthDef
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic                          i_fifo_full,
  output logic                          o_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         o_fifo_wr_data,
  output logic                          o_grant_valid,
  output logic [ID_WIDTH-1:0]           o_grant_id
);

  localparam int unsigned BeatW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BeatW-1:0] BeatLast = BeatW'(MAX_BURST - 1);
  localparam logic [BeatW-1:0] BeatOne  = BeatW'(1);
  localparam logic [ID_WIDTH-1:0] IdMax = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [ID_WIDTH-1:0] IdOne = ID_WIDTH'(1);

  arb_state_t          state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [BeatW-1:0]    beat_cnt_q, beat_cnt_d;

  logic                busy;
  logic [NUM_REQ-1:0]  owner_mask;
  logic                owner_valid;
  logic                owner_last;
  logic                accept;
  logic                release_grant;
  logic [ID_WIDTH-1:0] ptr_after;
  logic [ID_WIDTH-1:0] pick_start;
  logic                pick_found;
  logic [ID_WIDTH-1:0] pick_idx;

  // Owner decode and the accept/release conditions for the current burst.
  always_comb begin
    busy          = (state_q == ARB_BUSY);
    owner_mask    = NUM_REQ'(1) << grant_q;
    owner_valid   = |(i_req_valid & owner_mask);
    owner_last    = |(i_req_last & owner_mask);
    accept        = busy && owner_valid && !i_fifo_full;
    // Full only stalls; an idle owner or a finished burst hands the port on.
    release_grant = busy && (!owner_valid ||
                             (accept && (owner_last || (beat_cnt_q == BeatLast))));
    ptr_after     = (grant_q == IdMax) ? '0 : grant_q + IdOne;
    // Release re-arbitration starts after the owner, so the owner is checked last.
    pick_start    = busy ? ptr_after : rr_ptr_q;
  end

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_pick (
    .req_i   (i_req_valid),
    .start_i (pick_start),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Next-state: grant from idle, count beats, rotate on release without a bubble.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d    = ARB_BUSY;
          grant_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      ARB_BUSY: begin
        if (release_grant) begin
          rr_ptr_d   = ptr_after;
          beat_cnt_d = '0;
          if (pick_found) begin
            grant_d = pick_idx;
          end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
          end
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + BeatOne;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Zero-latency pass-through of the owner onto the FIFO write port.
  always_comb begin
    o_grant_valid  = busy;
    o_grant_id     = busy ? grant_q : '0;
    o_req_ready    = (busy && !i_fifo_full) ? owner_mask : '0;
    o_fifo_wr_en   = accept;
    o_fifo_wr_data = busy ? DATA_WIDTH'(i_req_data >> (32'(grant_q) * DATA_WIDTH)) : '0;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic,
// all compared cycle by cycle against a behavioural ownership model.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] valid;
  logic [NR-1:0] last;
  logic [NR*DW-1:0] data;
  logic [NR-1:0] ready;
  logic          full;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          gv;
  logic [1:0]    gid;

  int checks = 0;
  int errors = 0;

  // Pending beats per producer: {last, data}.
  logic [8:0] rq [NR][$];
  // Observed FIFO writes: {grant_id, data}.
  logic [9:0] dut_log[$];

  // Reference model: current owner (-1 = none), next search start, beats in burst.
  int m_own = -1;
  int m_ptr = 0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB),
    .ID_WIDTH   (2)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req_valid    (valid),
    .i_req_last     (last),
    .i_req_data     (data),
    .o_req_ready    (ready),
    .i_fifo_full    (full),
    .o_fifo_wr_en   (wr_en),
    .o_fifo_wr_data (wr_data),
    .o_grant_valid  (gv),
    .o_grant_id     (gid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ent(input int id, input int d);
    return 32'((id << 8) | d);
  endfunction

  function automatic int pick(input int start);
    for (int i = 0; i < NR; i++) begin
      if (valid[(start + i) % NR]) return (start + i) % NR;
    end
    return -1;
  endfunction

  // Present the head of each producer queue.
  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      valid[k] = (rq[k].size() > 0);
      if (valid[k]) begin
        last[k]         = rq[k][0][8];
        data[k*DW +: DW] = rq[k][0][7:0];
      end else begin
        last[k]         = 1'b0;
        data[k*DW +: DW] = 8'h00;
      end
    end
  endtask

  // One clock: check outputs at the negedge, advance the model across the posedge.
  task automatic step();
    int n_own, n_ptr, n_cnt;
    int acc_id;
    logic exp_wr;
    drive();
    @(negedge clk);
    exp_wr = (m_own >= 0) && valid[m_own] && !full;
    chk("grant_valid", 32'(gv), 32'(m_own >= 0));
    chk("grant_id", 32'(gid), (m_own >= 0) ? 32'(m_own) : 32'd0);
    chk("ready", 32'(ready), (m_own >= 0 && !full) ? 32'(1 << m_own) : 32'd0);
    chk("wr_en", 32'(wr_en), 32'(exp_wr));
    if (exp_wr) chk("wr_data", 32'(wr_data), 32'(data[m_own*DW +: DW]));
    if (wr_en === 1'b1) dut_log.push_back({gid, wr_data});
    n_own  = m_own;
    n_ptr  = m_ptr;
    n_cnt  = m_cnt;
    acc_id = exp_wr ? m_own : -1;
    if (m_own < 0) begin
      n_own = pick(m_ptr);
      n_cnt = 0;
    end else if (!valid[m_own] || (exp_wr && (m_cnt + 1 == MB || last[m_own]))) begin
      n_ptr = (m_own + 1) % NR;
      n_own = pick(n_ptr);
      n_cnt = 0;
    end else if (exp_wr) begin
      n_cnt = m_cnt + 1;
    end
    @(posedge clk);
    #1;
    m_own = n_own;
    m_ptr = n_ptr;
    m_cnt = n_cnt;
    if (acc_id >= 0) void'(rq[acc_id].pop_front());
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_gv"}, 32'(gv), 32'd0);
    chk({tag, "_gid"}, 32'(gid), 32'd0);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
  endtask

  task automatic model_reset();
    m_own = -1;
    m_ptr = 0;
    m_cnt = 0;
    for (int k = 0; k < NR; k++) rq[k].delete();
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [31:0] exp);
    chk(tag, (idx < dut_log.size()) ? 32'(dut_log[idx]) : 32'hFFFF_FFFF, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    full  = 1'b0;
    valid = '0;
    last  = '0;
    data  = '0;

    // Reset with every producer valid: outputs stay 0, then req0 wins first.
    for (int k = 0; k < NR; k++) rq[k].push_back({1'b1, 8'(8'h10 + k)});
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    dut_log.delete();
    repeat (8) step();
    chk("t1_count", 32'(dut_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk_log("t1_order", i, ent(i, 8'h10 + i));

    // All producers streaming without last: 4-beat bursts rotating 0,1,2,3,0,...
    dut_log.delete();
    for (int k = 0; k < NR; k++)
      for (int j = 0; j < 8; j++) rq[k].push_back({1'b0, 8'((k << 4) | j)});
    repeat (33) step();
    chk("t3_count", 32'(dut_log.size()), 32'd32);
    for (int i = 0; i < 32; i++) begin
      int id;
      id = (i / 4) % 4;
      chk_log("t3_burst", i, ent(id, (id << 4) | ((i / 16) * 4 + i % 4)));
    end
    repeat (2) step();

    // Single req2 packet A1,A2,A3.
    dut_log.delete();
    rq[2].push_back({1'b0, 8'hA1});
    rq[2].push_back({1'b0, 8'hA2});
    rq[2].push_back({1'b1, 8'hA3});
    repeat (5) step();
    chk("t2_count", 32'(dut_log.size()), 32'd3);
    chk_log("t2_a1", 0, ent(2, 8'hA1));
    chk_log("t2_a2", 1, ent(2, 8'hA2));
    chk_log("t2_a3", 2, ent(2, 8'hA3));

    // Full stalls req1 mid-burst; the grant holds, then the burst finishes and rotates.
    dut_log.delete();
    for (int j = 0; j < 4; j++) rq[1].push_back({1'b0, 8'(8'h31 + j)});
    rq[2].push_back({1'b1, 8'h41});
    repeat (3) step();
    full = 1'b1;
    repeat (3) step();
    full = 1'b0;
    repeat (4) step();
    chk("t4_count", 32'(dut_log.size()), 32'd5);
    for (int j = 0; j < 4; j++) chk_log("t4_req1", j, ent(1, 8'h31 + j));
    chk_log("t4_rotate", 4, ent(2, 8'h41));

    // req0 packet ends on beat 2; req3 takes over with no idle cycle.
    dut_log.delete();
    rq[0].push_back({1'b0, 8'h50});
    rq[0].push_back({1'b1, 8'h51});
    rq[0].push_back({1'b0, 8'h52});
    rq[0].push_back({1'b1, 8'h53});
    step();
    for (int j = 0; j < 4; j++) rq[3].push_back({1'(j == 3), 8'(8'h60 + j)});
    repeat (9) step();
    chk("t5_count", 32'(dut_log.size()), 32'd8);
    chk_log("t5_b0", 0, ent(0, 8'h50));
    chk_log("t5_b1", 1, ent(0, 8'h51));
    for (int j = 0; j < 4; j++) chk_log("t5_req3", 2 + j, ent(3, 8'h60 + j));
    chk_log("t5_b2", 6, ent(0, 8'h52));
    chk_log("t5_b3", 7, ent(0, 8'h53));

    // req1 goes idle after one beat; grant moves to req2, then reset lands mid-burst.
    dut_log.delete();
    rq[1].push_back({1'b0, 8'h70});
    rq[2].push_back({1'b0, 8'h80});
    rq[2].push_back({1'b0, 8'h81});
    rq[2].push_back({1'b1, 8'h82});
    repeat (4) step();
    drive();
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("async_rst");
    model_reset();
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step();
    chk("t6_count", 32'(dut_log.size()), 32'd2);
    chk_log("t6_req1", 0, ent(1, 8'h70));
    chk_log("t6_req2", 1, ent(2, 8'h80));

    // Random traffic and back-pressure.
    for (int c = 0; c < 500; c++) begin
      for (int k = 0; k < NR; k++) begin
        if (rq[k].size() == 0 && $urandom_range(0, 3) == 0) begin
          int len;
          logic use_last;
          len      = $urandom_range(1, 7);
          use_last = 1'($urandom_range(0, 1));
          for (int j = 0; j < len; j++)
            rq[k].push_back({(j == len - 1) && use_last, 8'($urandom)});
        end
      end
      full = ($urandom_range(0, 3) == 0);
      step();
    end
    full = 1'b0;
    repeat (60) step();
    for (int k = 0; k < NR; k++) chk("drained", 32'(rq[k].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
